// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_pkg: shared defaults and select-width helper for regfile_sb        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  localparam int REGF_DATA_W   = 8;
  localparam int REGF_NUM_REGS = 4;

  function automatic int regf_sel_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_scoreboard: per-register busy bits with set-over-clear priority    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NUM_REGS = REGF_NUM_REGS,
  parameter bit  ZERO_R0  = 1'b0,
  localparam int SEL_W    = regf_sel_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [SEL_W-1:0]    i_wr_sel,
  input  logic                i_set_en,
  input  logic [SEL_W-1:0]    i_set_sel,
  output logic [NUM_REGS-1:0] o_busy,
  output logic                o_any_busy
);

  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_q;

  // A new load issued on the same edge as a write supersedes that write.
  always_comb begin
    busy_d = busy_q;
    if (i_wr_en) busy_d[i_wr_sel] = 1'b0;
    if (i_set_en) busy_d[i_set_sel] = 1'b1;
    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign o_busy     = busy_q;
  assign o_any_busy = |busy_q;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_sb: 2R/1W register file with optional bypass and busy scoreboard   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = REGF_DATA_W,
  parameter int  NUM_REGS = REGF_NUM_REGS,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  ZERO_R0  = 1'b0,
  localparam int SEL_W    = regf_sel_w(NUM_REGS)
) (
  input  logic              CLK,
  input  logic              areset,
  input  logic [SEL_W-1:0]  selector_a,
  input  logic [SEL_W-1:0]  selector_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              write_bit,
  input  logic [SEL_W-1:0]  selector_e,
  input  logic [DATA_W-1:0] data_in,
  input  logic              busy_set,
  input  logic [SEL_W-1:0]  busy_sel,
  output logic              any_busy
);

  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_w;

  always_comb begin
    regs_d = regs_q;
    if (write_bit && !(ZERO_R0 && selector_e == '0)) regs_d[selector_e] = data_in;
  end

  always_ff @(posedge CLK) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_R0  (ZERO_R0)
  ) u_scoreboard (
    .clk        (CLK),
    .rst        (areset),
    .i_wr_en    (write_bit),
    .i_wr_sel   (selector_e),
    .i_set_en   (busy_set),
    .i_set_sel  (busy_sel),
    .o_busy     (busy_w),
    .o_any_busy (any_busy)
  );

  // Forwarding stays live during areset; reset only acts at the edge.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] rd_data;
    logic              rd_busy;

    assign sel = (p == 0) ? selector_a : selector_b;

    always_comb begin
      rd_data = regs_q[sel];
      rd_busy = busy_w[sel];
      if (ZERO_R0 && sel == '0) begin
        rd_data = '0;
        rd_busy = 1'b0;
      end else if (BYPASS && write_bit && selector_e == sel) begin
        rd_data = data_in;
        rd_busy = 1'b0;
      end
    end
  end

  assign data_out_a = g_rd[0].rd_data;
  assign busy_a     = g_rd[0].rd_busy;
  assign data_out_b = g_rd[1].rd_data;
  assign busy_b     = g_rd[1].rd_busy;

endmodule
`default_nettype wire
